// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, decoder function and converter FSM states
//
// Segment codes are active-high with bit 0 = segment a .. bit 6 = segment g.
// Polarity inversion for the board pins is applied in the top level.

package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_COMMIT = 2'd2
  } conv_state_e;

  // Non-decimal nibbles cannot come out of the converter; they map to blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with commit register
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : start conversion of bin_in (ignored while busy)
//   bin_in    : unsigned binary value, BIN_W bits
//   busy      : conversion or commit in progress
//   done      : one-cycle pulse when bcd/overflow take the new value
//   overflow  : committed value exceeded 10^NUM_DIGITS-1
//   bcd       : committed NUM_DIGITS BCD nibbles, nibble 0 least significant

module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  // Scratch must hold every decimal digit BIN_W bits can produce (one digit
  // per ~3.3 bits), and at least the displayed digits.
  localparam int NEED_D = (BIN_W + 2) / 3;
  localparam int SCR_D  = (NEED_D > NUM_DIGITS) ? NEED_D : NUM_DIGITS;
  localparam int SCR_W  = 4 * SCR_D;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  conv_state_e             state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [SCR_W-1:0]        scr_q, scr_d;
  logic [SCR_W-1:0]        adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_pend_q, ovf_pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    done_d     = 1'b0;

    // Add-3 correction so each nibble carries correctly into the next on shift.
    adj = scr_q;
    for (int i = 0; i < SCR_D; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          bin_d      = bin_in;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(bin_in) > MAX_VAL);
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        {scr_d, bin_d} = {adj, bin_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        bcd_d   = scr_q[4*NUM_DIGITS-1:0];
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;

endmodule

// File: rtl/seg7_mux_display.sv
// rtl/seg7_mux_display.sv - time-multiplexed multi-digit 7-segment driver with BCD conversion
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : start conversion of bin_in (ignored while busy)
//   bin_in    : unsigned value to display, BIN_W bits
//   busy      : conversion in progress
//   done      : one-cycle pulse when a new value is committed to the display
//   overflow  : committed value exceeded 10^NUM_DIGITS-1; all digits show dash
//   seg       : segment lines, seg[0]=a .. seg[6]=g
//   an        : one-hot digit enables, an[0] = least significant digit
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   : leading zero digits (never digit 0) are shown blank
//   undefined : all digits shown, including leading zeros

module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic                    disp_ovf;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            nibble;
  logic [6:0]            code;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                  all_zero;
`endif

  bin2bcd_seq #(
    .BIN_W      (BIN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (disp_ovf),
    .bcd      (disp_bcd)
  );

  assign overflow = disp_ovf;

  // Free-running refresh counter and digit index.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero = all_zero & (disp_bcd[4*i +: 4] == 4'd0);
      blank[i] = all_zero;
    end
`endif
  end

  always_comb begin
    nibble = disp_bcd[4*idx_q +: 4];
    if (disp_ovf) begin
      code = SEG_DASH;
    end else if (blank[idx_q]) begin
      code = SEG_BLANK;
    end else begin
      code = bcd_to_seg(nibble);
    end
    seg_d = ACTIVE_LOW ? ~code : code;

    onehot        = '0;
    onehot[idx_q] = 1'b1;
    an_d          = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: doc/seg7_mux_display.md
Name: seg7_mux_display

Overview:
- Multi-digit, time-multiplexed 7-segment display driver and the successor to the single-digit decimal-to-segment decoder.
- Accepts an unsigned binary value on a load strobe and converts it to BCD with a sequential double-dabble engine.
- Scans NUM_DIGITS common-anode digits through shared segment lines.
- Sits between datapath results and the board's display pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits (1..8)
BIN_W, 14, width of binary input
REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2)
ACTIVE_LOW, 1, 1 = seg and an driven active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  start conversion of bin_in; honoured only when busy=0
bin_in  in  BIN_W  unsigned value to display
busy  out  1  conversion in progress; load ignored
done  out  1  one-cycle pulse when the new value is committed to the display
overflow  out  1  latched: last committed value > 10^NUM_DIGITS-1
seg  out  7  segments, seg[0]=a .. seg[6]=g
an  out  NUM_DIGITS  digit enables, one-hot, an[0] = least significant digit

Behaviour:
- Clocking and reset:
  - One clock (clk); reset (rst) is asynchronous and active-high.
  - While rst=1: busy=0, done=0, overflow=0, display BCD register=0, digit index=0, refresh counter=0.
  - While rst=1, an is all inactive and seg is all off.
  - All outputs are registered.
- Conversion FSM states: IDLE, CONV, COMMIT.
  - IDLE: when load=1, capture bin_in into the shift register, clear BCD scratch, clear the bit counter, latch ovf_pend = (bin_in > 10^NUM_DIGITS-1), and go to CONV.
  - CONV: each cycle, add 3 to every scratch BCD nibble >=5, then shift left 1 bit from the binary register. After BIN_W shifts, go to COMMIT.
  - COMMIT: copy the NUM_DIGITS scratch nibbles to the display register, set overflow=ovf_pend, pulse done=1 for this cycle, return to IDLE.
  - busy=1 in CONV and COMMIT.
- Latency: load sampled at edge N -> done high in the cycle following edge N+BIN_W+1. The display changes at that same edge.
- load while busy: ignored; no queueing.
- The display register is updated atomically at COMMIT only. The old value stays displayed during conversion.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At the terminal count it wraps to 0 and the digit index advances mod NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - an enables the current index only. seg carries that digit's code in the same cycle.
  - After reset release, digit 0 is driven at the first clock edge.
- Segment codes (active-high; inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - dash=40, blank=00.
- overflow=1: every digit shows dash; the BCD register content is not shown.
- Reset mid-conversion aborts the conversion. No done pulse. The display returns to all zeros.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: zero digits above the most significant nonzero digit show blank. Digit 0 is never blanked, so value 0 shows a single "0". Blanking is combinational on the display register and applied before the output register. Overflow dashes take priority.
- Undefined: all digits always shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK)
  - function bcd_to_seg(nibble)
  - FSM state encodings
- Sub-module bin2bcd_seq (BIN_W, NUM_DIGITS): contains the double-dabble FSM with load/busy/done handshake and ovf_pend.
- The top level holds the scan counter, digit mux, blanking and output registers.

Test Plan (NUM_DIGITS=4, BIN_W=14, REFRESH_DIV=4, ACTIVE_LOW=1):
1. Release rst -> an cycles E,D,B,7, each held 4 clocks, repeating; seg=40 ("0") on every digit; busy=0; done=0.
2. load bin_in=1234 -> busy high for 15 cycles; done pulses once, 15 cycles after load; digit0 seg=19 ("4"), digit1=30, digit2=24, digit3=79 ("1").
3. load 9999 -> all digits seg=10, overflow=0. Then load 10000 -> overflow=1, all digits seg=3F (dash). Then load 5 -> overflow=0.
4. load 42, then load 7 asserted 2 cycles later -> the second load is ignored; exactly one done pulse; display 0042.
5. Assert rst 6 cycles into a conversion of 1234 -> busy=0 immediately; no done pulse; display 0000; an all inactive during reset.
6. With SEG7_LEADING_ZERO_BLANK_EN, load 7 -> digits 3..1 seg=7F (blank), digit0 seg=78. Load 0 -> digit0 seg=40, others blank.
